// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared types and helpers for the AXI4-Lite slave register file.
//   RESP_W     : width of the BRESP/RRESP fields
//   resp_e     : response codes the slave can return (OKAY, SLVERR)
//   addr2idx() : byte address -> word index (drops the byte-lane bits)
// ---------------------------------------------------------------------------
package axil_pkg;

    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    // Unaligned low address bits are simply shifted away.
    function automatic int unsigned addr2idx(input int unsigned addr,
                                             input int unsigned word_shift);
        return addr >> word_shift;
    endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// ---------------------------------------------------------------------------
// axil_wr_capture
// One-entry holding latches for the AXI4-Lite AW and W channels plus their
// registered ready outputs. AW and W are accepted independently; the parent
// pulses `commit` when it consumes both latches.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   awaddr/awvalid      AW channel in;   awready out
//   wdata/wstrb/wvalid  W channel in;    wready out
//   commit              parent consumes both latches on this edge
//   bvalid_next         value bvalid will hold after this edge
//   aw_held/w_held      latch occupancy flags
//   aw_addr/w_data/w_strb latched payloads (valid only while held)
// ---------------------------------------------------------------------------
module axil_wr_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  commit,
    input  logic                  bvalid_next,
    output logic                  aw_held,
    output logic                  w_held,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [STRB_W-1:0]     w_strb
);

    logic aw_hs;
    logic w_hs;
    logic aw_held_next;
    logic w_held_next;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A latch cannot fill on the commit edge (its ready is low while held),
    // so commit simply empties it.
    assign aw_held_next = commit ? 1'b0 : (aw_held || aw_hs);
    assign w_held_next  = commit ? 1'b0 : (w_held || w_hs);

    // Readies are registered from next-state values so they drop on the very
    // edge that fills a latch and never allow a second beat in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
        end else begin
            aw_held <= aw_held_next;
            w_held  <= w_held_next;
            awready <= !aw_held_next && !bvalid_next;
            wready  <= !w_held_next && !bvalid_next;
        end
    end

    // Payloads are qualified by the held flags, so they need no reset.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr <= awaddr;
        if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
        end
    end

endmodule

// File: rtl/axil_slave_regfile.sv
// ---------------------------------------------------------------------------
// axil_slave_regfile
// AXI4-Lite slave exposing NUM_REGS word registers with byte-strobe writes.
// Out-of-range word indices return SLVERR; writes to them are dropped and
// reads return zero. One write and one read may be outstanding at a time.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
// ---------------------------------------------------------------------------
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [RESP_W-1:0]     bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [RESP_W-1:0]     rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int unsigned WORD_SHIFT = $clog2(STRB_W);
    localparam int unsigned NREG       = NUM_REGS;
    localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  commit;
    logic                  bvalid_next;

    int unsigned           wr_idx;
    logic                  wr_ok;
    logic [IDX_W-1:0]      wr_slot;

    int unsigned           rd_idx;
    logic                  rd_ok;
    logic [IDX_W-1:0]      rd_slot;
    logic                  ar_hs;
    logic                  rvalid_next;

    axil_wr_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .commit      (commit),
        .bvalid_next (bvalid_next),
        .aw_held     (aw_held),
        .w_held      (w_held),
        .aw_addr     (aw_addr),
        .w_data      (w_data),
        .w_strb      (w_strb)
    );

    // Write decode works on the latched address, read decode on the live one.
    assign wr_idx  = addr2idx(32'(aw_addr), WORD_SHIFT);
    assign wr_ok   = wr_idx < NREG;
    assign wr_slot = wr_idx[IDX_W-1:0];

    assign rd_idx  = addr2idx(32'(araddr), WORD_SHIFT);
    assign rd_ok   = rd_idx < NREG;
    assign rd_slot = rd_idx[IDX_W-1:0];

    assign commit      = aw_held && w_held && !bvalid;
    assign bvalid_next = commit || (bvalid && !bready);

    assign ar_hs       = arvalid && arready;
    assign rvalid_next = ar_hs || (rvalid && !rready);

    // Write path: sole writer of the register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            bvalid <= 1'b0;
            bresp  <= OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? OKAY : SLVERR;
            if (wr_ok) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_strb[b]) regs[wr_slot][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

    // Read path: samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            arready <= !rvalid_next;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_ok ? regs[rd_slot] : '0;
                rresp  <= rd_ok ? OKAY : SLVERR;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
module tb_axil_slave_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axil_slave_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .NUM_REGS   (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    // Inputs change and outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W together; returns the B response or a timeout flag.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output logic to);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        to = (bvalid !== 1'b1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output logic to);
        int n;
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
        to = (rvalid !== 1'b1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (3) tick();
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
            rdata !== 32'h0 || rresp !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy/vld=%b bresp=%b rdata=%h rresp=%b, expected all 0",
                     {awready, wready, arready, bvalid, rvalid}, bresp, rdata, rresp);
        end
        rst_n = 1'b1;
        vectors++;
        if ({awready, wready, arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b, expected 000", {awready, wready, arready});
        end
        tick();
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b, expected 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] d; logic [1:0] r; logic to;
        awaddr = 16'h0004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        vectors++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
            miscompares++;
            $display("FAIL sc_after_hs: got bvalid=%b awready=%b wready=%b, expected 0 0 0",
                     bvalid, awready, wready);
        end
        tick();
        vectors++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL sc_bvalid: got bvalid=%b bresp=%b, expected 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(16'h0004, d, r, to);
        vectors++;
        if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin
            miscompares++;
            $display("FAIL sc_readback: got to=%b rdata=%h rresp=%b, expected 0 deadbeef 00", to, d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r; logic to;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
                miscompares++;
                $display("FAIL w_held_wait: got wready=%b bvalid=%b awready=%b, expected 0 0 1",
                         wready, bvalid, awready);
            end
            tick();
        end
        awaddr = 16'h0008; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        vectors++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b0) begin
            miscompares++;
            $display("FAIL wa_bvalid: got bvalid=%b bresp=%b wready=%b, expected 1 00 0",
                     bvalid, bresp, wready);
        end
        tick();
        vectors++;
        if (wready !== 1'b0) begin
            miscompares++;
            $display("FAIL wa_wready_pending_b: got %b, expected 0", wready);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        vectors++;
        if (wready !== 1'b1 || awready !== 1'b1 || bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wa_after_b: got wready=%b awready=%b bvalid=%b, expected 1 1 0",
                     wready, awready, bvalid);
        end
        do_read(16'h0008, d, r, to);
        vectors++;
        if (to || d !== 32'h00220044 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL wa_readback: got to=%b rdata=%h rresp=%b, expected 0 00220044 00", to, d, r);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; logic to;
        do_write(16'h0040, 32'hCAFEF00D, 4'hF, r, to);
        vectors++;
        if (to || r !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_bresp: got to=%b bresp=%b, expected 0 10", to, r);
        end
        do_read(16'h0040, d, r, to);
        vectors++;
        if (to || d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_read: got to=%b rdata=%h rresp=%b, expected 0 00000000 10", to, d, r);
        end
        do_read(16'h0000, d, r, to);
        vectors++;
        if (to || d !== 32'h0 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL oor_reg0_untouched: got rdata=%h rresp=%b, expected 00000000 00", d, r);
        end
        // Unaligned address 0x0006 still selects word 1.
        do_read(16'h0006, d, r, to);
        vectors++;
        if (to || d !== 32'hDEADBEEF || r !== 2'b00) begin
            miscompares++;
            $display("FAIL unaligned_read: got rdata=%h rresp=%b, expected deadbeef 00", d, r);
        end
        do_write(16'h003C, 32'hA5A5A5A5, 4'hF, r, to);
        do_read(16'h003C, d, r, to);
        vectors++;
        if (to || d !== 32'hA5A5A5A5 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL last_reg: got rdata=%h rresp=%b, expected a5a5a5a5 00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; logic to;
        awaddr = 16'h000C; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                miscompares++;
                $display("FAIL b_hold cycle %0d: got bvalid=%b bresp=%b awready=%b wready=%b, expected 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        araddr = 16'h000C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rvalid !== 1'b1 || rdata !== 32'h0BADF00D || rresp !== 2'b00 || arready !== 1'b0) begin
                miscompares++;
                $display("FAIL r_hold cycle %0d: got rvalid=%b rdata=%h rresp=%b arready=%b, expected 1 0badf00d 00 0",
                         i, rvalid, rdata, rresp, arready);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        vectors++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            miscompares++;
            $display("FAIL r_release: got rvalid=%b arready=%b, expected 0 1", rvalid, arready);
        end
        do_write(16'h000C, 32'hFFFFFFFF, 4'h0, r, to);
        do_read(16'h000C, d, r, to);
        vectors++;
        if (to || d !== 32'h0BADF00D || r !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_strb: got rdata=%h rresp=%b, expected 0badf00d 00", d, r);
        end
    endtask

    task automatic test_read_write_collision();
        logic [31:0] d; logic [1:0] r; logic to;
        awaddr = 16'h0010; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 16'h0010; arvalid = 1'b1;
        tick();  // commit and AR handshake on the same edge
        arvalid = 1'b0;
        vectors++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL collide_old_value: got bvalid=%b rvalid=%b rdata=%h, expected 1 1 00000000",
                     bvalid, rvalid, rdata);
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(16'h0010, d, r, to);
        vectors++;
        if (to || d !== 32'h12345678) begin
            miscompares++;
            $display("FAIL collide_new_value: got rdata=%h, expected 12345678", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [1:0] r; logic to;
        awaddr = 16'h0014; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %b, expected 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        rst_n = 1'b1;
        tick();
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (3) tick();
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_commit: got bvalid=%b, expected 0", bvalid);
        end
        do_read(16'h0014, d, r, to);
        vectors++;
        if (to || d !== 32'h0 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset_read: got rdata=%h rresp=%b, expected 00000000 00", d, r);
        end
        do_read(16'h0004, d, r, to);
        vectors++;
        if (to || d !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_cleared: got rdata=%h, expected 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_read_write_collision();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
